// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO for the audio path: occupancy, thresholds, flush, sticky errors,
// and a selectable standard or first-word-fall-through read port.
module audio_sample_fifo #(
  parameter int unsigned ABITS    = 4,
  parameter int unsigned DBITS    = 16,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr,
  input  logic [DBITS-1:0] din,
  input  logic             rd,
  output logic [DBITS-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ABITS:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam int unsigned DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] DepthLvl = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AfLvl    = (ABITS+1)'(AF_LEVEL);
  localparam logic [ABITS:0] AeLvl    = (ABITS+1)'(AE_LEVEL);

  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL >= 1 && AF_LEVEL <= DEPTH)) begin : gen_param_check
    $error("audio_sample_fifo: illegal AE_LEVEL/AF_LEVEL for DEPTH");
  end

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   level_q, level_d;
  logic [DBITS-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;

  // Flags decode only the registered level, never the live requests.
  assign empty        = (level_q == '0);
  assign full         = (level_q == DepthLvl);
  assign almost_empty = (level_q <= AeLvl);
  assign almost_full  = (level_q >= AfLvl);
  assign level        = level_q;
  assign dout         = dout_q;
  assign dout_valid   = FWFT ? ~empty : dout_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_acc       = rd & ~empty & ~flush;
    wr_acc       = wr & (~full | rd_acc) & ~flush;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ABITS'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ABITS'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + (ABITS+1)'(1);
        2'b01:   level_d = level_q - (ABITS+1)'(1);
        default: level_d = level_q;
      endcase
    end

    if (!FWFT) begin
      if (rd_acc) begin
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end
    end else if (!flush && level_d != '0) begin
      // The new head is the word being written when it lands at the next read address.
      dout_d = (wr_acc && wr_ptr_q == rd_ptr_d) ? din : mem_q[rd_ptr_d];
    end

    overflow_d  = (wr & full & ~rd & ~flush) | (overflow_q & ~clear_err);
    underflow_d = (rd & empty & ~flush) | (underflow_q & ~clear_err);
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: a standard-read and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue-based model of the FIFO.
module tb_audio_sample_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] s_dout, f_dout;
  logic        s_dv, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic        f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [4:0]  s_level, f_level;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: queue contents, standard-port output register, sticky errors.
  logic [15:0] mq[$];
  logic [15:0] m_dout = '0;
  logic        m_dv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  audio_sample_fifo #(.ABITS(4), .DBITS(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b0)) u_std (
    .clock(clock), .reset(reset), .flush(flush), .wr(wr), .din(din), .rd(rd),
    .dout(s_dout), .dout_valid(s_dv), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .level(s_level),
    .overflow(s_ovf), .underflow(s_udf), .clear_err(clear_err)
  );

  audio_sample_fifo #(.ABITS(4), .DBITS(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
    .clock(clock), .reset(reset), .flush(flush), .wr(wr), .din(din), .rd(rd),
    .dout(f_dout), .dout_valid(f_dv), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf), .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Next state of the FIFO from the inputs presented before the coming edge.
  task automatic model_step();
    int sz;
    bit ra, wa;
    sz = mq.size();
    m_ovf = (!flush && wr && sz == DEPTH && !rd) || (m_ovf && !clear_err);
    m_udf = (!flush && rd && sz == 0) || (m_udf && !clear_err);
    if (flush) begin
      mq.delete();
      m_dv = 1'b0;
    end else begin
      ra = rd && sz > 0;
      wa = wr && (sz < DEPTH || ra);
      m_dv = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(din);
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = mq.size();
    chk("s_level", 32'(s_level), 32'(sz));
    chk("s_empty", 32'(s_empty), 32'(sz == 0));
    chk("s_full",  32'(s_full),  32'(sz == DEPTH));
    chk("s_ae",    32'(s_ae),    32'(sz <= 2));
    chk("s_af",    32'(s_af),    32'(sz >= 12));
    chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("s_udf",   32'(s_udf),   32'(m_udf));
    chk("s_dout",  32'(s_dout),  32'(m_dout));
    chk("s_dv",    32'(s_dv),    32'(m_dv));
    chk("f_level", 32'(f_level), 32'(sz));
    chk("f_empty", 32'(f_empty), 32'(sz == 0));
    chk("f_full",  32'(f_full),  32'(sz == DEPTH));
    chk("f_ae",    32'(f_ae),    32'(sz <= 2));
    chk("f_af",    32'(f_af),    32'(sz >= 12));
    chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
    chk("f_udf",   32'(f_udf),   32'(m_udf));
    chk("f_dv",    32'(f_dv),    32'(sz != 0));
    if (sz != 0) chk("f_dout", 32'(f_dout), 32'(mq[0]));
  endtask

  // Called a little after a rising edge; returns a little after the next one.
  task automatic cyc(input bit w, input logic [15:0] d, input bit r, input bit f, input bit ce);
    wr = w; din = d; rd = r; flush = f; clear_err = ce;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic async_reset_pulse();
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clear_err = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_level", 32'(s_level), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_ae",    32'(s_ae),    32'd1);
    chk("rst_af",    32'(s_af),    32'd0);
    chk("rst_dout",  32'(s_dout),  32'd0);
    chk("rst_dv",    32'(s_dv),    32'd0);
    chk("rst_ovf",   32'(s_ovf),   32'd0);
    chk("rst_udf",   32'(s_udf),   32'd0);
    chk("rst_fdout", 32'(f_dout),  32'd0);
    chk("rst_fdv",   32'(f_dv),    32'd0);
    compare_all();
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    int wp;
    // Initial reset, released between edges.
    #22;
    compare_all();
    chk("init_empty", 32'(s_empty), 32'd1);
    reset = 1'b0;

    // Fill to full, watch almost_full threshold, then overflow.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      if (i == 1)  chk("fwft_first", 32'(f_dout), 32'h0001);
      if (i == 11) chk("af_at_11", 32'(s_af), 32'd0);
      if (i == 12) chk("af_at_12", 32'(s_af), 32'd1);
    end
    chk("full_flag", 32'(s_full), 32'd1);
    chk("full_level", 32'(s_level), 32'd16);
    cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_level", 32'(s_level), 32'd16);

    // Drain in order, then underflow with dout held.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("drain_dout", 32'(s_dout), 32'(i));
      chk("drain_dv", 32'(s_dv), 32'd1);
    end
    chk("drain_empty", 32'(s_empty), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("dv_pulse_end", 32'(s_dv), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("udf_set", 32'(s_udf), 32'd1);
    chk("udf_hold", 32'(s_dout), 32'h0010);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(s_ovf), 32'd0);
    chk("clr_udf", 32'(s_udf), 32'd0);

    // Full FIFO with simultaneous write/read for 20 cycles, then drain.
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0);
    chk("wr_rd_full_level", 32'(s_level), 32'd16);
    chk("wr_rd_full_ovf", 32'(s_ovf), 32'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("wrap_order", 32'(s_dout), 32'h1004 + 32'(k));
    end

    // Fall-through: a word into the empty FIFO shows up one clock later.
    cyc(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
    chk("fwft_dout", 32'(f_dout), 32'hABCD);
    chk("fwft_dv", 32'(f_dv), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_dv", 32'(f_dv), 32'd0);

    // Flush beats a same-cycle write; error flags survive it.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
    chk("flush_level", 32'(s_level), 32'd0);
    chk("flush_empty", 32'(s_empty), 32'd1);
    chk("flush_keeps_udf", 32'(s_udf), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("flush_clr_udf", 32'(s_udf), 32'd0);
    cyc(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
    chk("post_flush_level", 32'(s_level), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_flush_dout", 32'(s_dout), 32'h6666);

    // Asynchronous reset mid-burst at level 7.
    for (int i = 0; i < 7; i++) cyc(1'b1, 16'h0700 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(s_level), 32'd7);
    async_reset_pulse();
    cyc(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    chk("post_rst_fdout", 32'(f_dout), 32'h7777);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_dout", 32'(s_dout), 32'h7777);

    // Randomized traffic with shifting write/read bias, flushes, clears and resets.
    wp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) wp = 20 + 30 * int'($urandom_range(0, 2));
      if (c % 1000 == 999) begin
        async_reset_pulse();
      end else begin
        cyc(($urandom_range(0, 99) < wp), 16'($urandom), ($urandom_range(0, 99) < 100 - wp),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
Parametrised synchronous sample FIFO for the audio peripheral path. It buffers DBITS-wide samples between the sample producer and the DAC/serialiser consumer. It generalises the earlier 1-bit FIFO with the following features:
- all 2**ABITS entries usable
- occupancy output and programmable almost-full/almost-empty thresholds
- selectable standard or first-word-fall-through (FWFT) read mode
- synchronous flush
- sticky overflow/underflow error flags

Parameters:
ABITS, 4, address bits; DEPTH = 2**ABITS entries, all usable
DBITS, 16, sample width in bits
AF_LEVEL, 12, almost_full asserted when level >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard read (data 1 cycle after rd); 1 = head word presented on dout while not empty

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of contents and pointers
wr  input  1  write request, sampled each clock
din  input  DBITS  write data
rd  input  1  read request (FWFT=1: acknowledge/pop of head word)
dout  output  DBITS  read data, registered
dout_valid  output  1  FWFT=0: 1-cycle pulse with new dout; FWFT=1: equals ~empty
empty  output  1  level == 0
full  output  1  level == DEPTH
almost_empty  output  1  level <= AE_LEVEL
almost_full  output  1  level >= AF_LEVEL
level  output  ABITS+1  current occupancy 0..DEPTH
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty
clear_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async, any time, including mid-transfer):
  - wr_ptr, rd_ptr and level = 0; empty = 1; full = 0; almost_empty = 1; almost_full = 0
  - dout = 0; dout_valid = 0; overflow = 0; underflow = 0
  - memory contents are don't-care
- Request acceptance:
  - wr_acc = wr & (~full | rd_acc); rd_acc = rd & ~empty
  - If full with wr & rd in the same cycle, both are accepted and level is unchanged.
  - If empty with wr & rd in the same cycle, only the write is accepted and underflow is set.
- Pointers: ABITS wide, wrap naturally from DEPTH-1 to 0. Write stores din at mem[wr_ptr] on wr_acc.
- level update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH, never goes below 0.
- Flags:
  - empty, full, almost_* are decoded from the registered level, so they change in the same cycle as level.
  - Flags are registered or decoded from registers only; no combinational path from wr/rd to any flag.
- FWFT=0 (standard read):
  - On rd_acc, dout <= mem[rd_ptr] at the next edge and dout_valid pulses high for 1 cycle.
  - Otherwise dout holds its value and dout_valid = 0.
  - Latency rd -> data = 1 clock.
- FWFT=1 (fall-through):
  - dout always shows mem[rd_ptr] (registered head) whenever empty = 0; rd pops the head.
  - The next word appears on dout 1 clock after the pop.
  - A word written into an empty FIFO appears on dout, with dout_valid = 1, 1 clock after the write edge.
  - A write to mem[rd_ptr] while the FIFO is empty is bypassed to the output register.
- Errors:
  - overflow sets on wr & full & ~rd.
  - underflow sets on rd & empty.
  - Both hold until clear_err or reset; a set event coincident with clear_err wins (flag stays 1).
- flush:
  - Takes priority over wr/rd in the same cycle; that cycle's wr and rd are ignored.
  - Next edge: pointers = 0, level = 0, empty = 1, dout_valid = 0.
  - dout holds its value. Error flags are unaffected.
- Parameter legality: AE_LEVEL < AF_LEVEL and AF_LEVEL <= DEPTH. Violations are caught by an elaboration-time check; behaviour is undefined if violated.

Test Plan:
1. ABITS=4, DBITS=16, FWFT=0: write 0x0001..0x0010 (16 words) -> full=1, level=16, almost_full set when level reaches 12; 17th write gives overflow=1 and level stays 16.
2. Read 16 times from full -> dout sequence 0x0001..0x0010, each 1 clock after rd with a dout_valid pulse; empty=1 after the last; an extra rd gives underflow=1 and dout holds 0x0010.
3. Full FIFO with wr=rd=1 for 20 cycles (din=0x1000+i) -> level stays 16, no overflow, wrap-around order preserved on a subsequent drain.
4. FWFT=1: write 0xABCD into an empty FIFO -> dout=0xABCD with dout_valid=1 one clock later; rd pops and empty=1 on the next edge.
5. Write 5 words, assert flush together with wr=1 -> level=0, empty=1, written word discarded; clear_err clears prior overflow/underflow flags.
6. Assert reset asynchronously mid-burst at level=7 -> all outputs return to reset values immediately; the first write after release lands at address 0 and is read back correctly.
